// File: rtl/adc_mux_ctrl.sv
// Frame-aware select controller for the dual-source ADC mux: switches source only between
// frames, after a guard gap, then waits out the mux select latency. Optional watchdog: ADC_MUX_CTRL_TIMEOUT_EN.
module adc_mux_ctrl #(
  parameter int FRAME_CNT_W    = 8,
  parameter int GUARD_W        = 8,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
  input  logic [FRAME_CNT_W-1:0] cfg_frames,
  input  logic [GUARD_W-1:0]     cfg_guard,
  input  logic                   sw_req,
  input  logic                   sw_sel,
  input  logic                   err_clr,
  input  logic                   ch0_sop,
  input  logic                   ch0_eop,
  input  logic                   ch0_valid,
  input  logic                   ch1_sop,
  input  logic                   ch1_eop,
  input  logic                   ch1_valid,
  output logic                   adc_mux_s,
  output logic                   mux_busy,
  output logic                   switch_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   sop_drop_err,
  output logic                   frame_timeout
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = (GUARD_W > SET_W) ? GUARD_W : SET_W;

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("adc_mux_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_GUARD, ST_SETTLE} state_t;

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic                   r_sel, w_sel_next;
  logic                   r_busy, w_busy_next;
  logic                   r_done, w_done_next;
  logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
  logic                   r_pend_vld, w_pend_vld_next;
  logic                   r_pend_sel, w_pend_sel_next;
  logic                   r_drop_err, w_drop_set;

  logic                   w_sop, w_eop, w_to_hit;
  logic [FRAME_CNT_W-1:0] w_frames_min, w_cnt_inc;
  logic                   w_tgt_cur, w_tgt_inc;

  function automatic logic f_target(input logic [1:0] mode, input logic cur, input logic alt_due,
                                    input logic pend_vld, input logic pend_sel);
    logic tgt;
    case (mode)
      2'b00:   tgt = 1'b0;
      2'b01:   tgt = 1'b1;
      2'b10:   tgt = alt_due ? ~cur : cur;
      default: tgt = pend_vld ? pend_sel : cur;
    endcase
    return tgt;
  endfunction

  // Only the currently selected source's strobes drive the FSM
  assign w_sop = r_sel ? (ch1_sop & ch1_valid) : (ch0_sop & ch0_valid);
  assign w_eop = r_sel ? (ch1_eop & ch1_valid) : (ch0_eop & ch0_valid);

  assign w_frames_min = (cfg_frames == '0) ? FRAME_CNT_W'(1) : cfg_frames;
  assign w_cnt_inc    = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + FRAME_CNT_W'(1);
  assign w_tgt_cur    = f_target(cfg_mode, r_sel, r_frame_cnt >= w_frames_min, r_pend_vld, r_pend_sel);
  assign w_tgt_inc    = f_target(cfg_mode, r_sel, w_cnt_inc >= w_frames_min, r_pend_vld, r_pend_sel);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_sel_next       = r_sel;
    w_done_next      = 1'b0;
    w_frame_cnt_next = r_frame_cnt;
    w_drop_set       = 1'b0;
    case (r_state)
      ST_IDLE, ST_GUARD: begin
        if (w_sop && w_eop) begin
          // one-beat frame: count it and re-evaluate as at any eop
          w_frame_cnt_next = w_cnt_inc;
          w_state_next     = (w_tgt_inc != r_sel) ? ST_GUARD : ST_IDLE;
          w_cnt_next       = CNT_W'(cfg_guard);
        end else if (w_sop) begin
          w_state_next = ST_FRAME;
        end else if (r_state == ST_IDLE) begin
          if (w_tgt_cur != r_sel) begin
            w_state_next = ST_GUARD;
            w_cnt_next   = CNT_W'(cfg_guard);
          end
        end else if (w_tgt_cur == r_sel) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_sel_next   = w_tgt_cur;
          w_state_next = ST_SETTLE;
          w_cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_FRAME: begin
        if (w_eop) begin
          w_frame_cnt_next = w_cnt_inc;
          w_state_next     = (w_tgt_inc != r_sel) ? ST_GUARD : ST_IDLE;
          w_cnt_next       = CNT_W'(cfg_guard);
        end else if (w_to_hit) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        // r_sel already points at the new source, so w_sop is a sop on the new source
        w_drop_set = w_sop;
        if (r_cnt == '0) begin
          w_done_next      = 1'b1;
          w_frame_cnt_next = '0;
          w_state_next     = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
    endcase
    w_busy_next = (w_state_next == ST_GUARD) || (w_state_next == ST_SETTLE);
  end

  always_comb begin
    w_pend_vld_next = r_pend_vld;
    w_pend_sel_next = r_pend_sel;
    if (sw_req) begin
      w_pend_vld_next = 1'b1;
      w_pend_sel_next = sw_sel;
    end else if (r_pend_vld && (w_done_next || (cfg_mode == 2'b11 && r_pend_sel == r_sel))) begin
      w_pend_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_sel  <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sel       <= w_sel_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_pend_vld  <= w_pend_vld_next;
      r_pend_sel  <= w_pend_sel_next;
      if (w_drop_set)
        r_drop_err <= 1'b1;
      else if (err_clr)
        r_drop_err <= 1'b0;
    end
  end

`ifdef ADC_MUX_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_err;

  assign w_to_hit = (r_state == ST_FRAME) && !w_eop && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_FRAME || w_eop || w_to_hit)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + TO_W'(1);
    if (rst)
      r_to_err <= 1'b0;
    else if (w_to_hit)
      r_to_err <= 1'b1;
    else if (err_clr)
      r_to_err <= 1'b0;
  end

  assign frame_timeout = r_to_err;
`else
  assign w_to_hit      = 1'b0;
  assign frame_timeout = 1'b0;
`endif

  assign adc_mux_s    = r_sel;
  assign mux_busy     = r_busy;
  assign switch_done  = r_done;
  assign frame_cnt    = r_frame_cnt;
  assign sop_drop_err = r_drop_err;

endmodule

// File: tb/tb_adc_mux_ctrl.sv
// Scoreboard bench for adc_mux_ctrl: each triggering eop pushes the expected select-change
// and switch_done edges; a negedge monitor pops and compares them as the DUT produces them.
module tb_adc_mux_ctrl;
  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_frames, cfg_guard;
  logic       sw_req, sw_sel, err_clr;
  logic       ch0_sop, ch0_eop, ch0_valid, ch1_sop, ch1_eop, ch1_valid;
  logic       adc_mux_s, mux_busy, switch_done, sop_drop_err, frame_timeout;
  logic [7:0] frame_cnt;

  adc_mux_ctrl #(.FRAME_CNT_W(8), .GUARD_W(8), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_frames(cfg_frames), .cfg_guard(cfg_guard),
    .sw_req(sw_req), .sw_sel(sw_sel), .err_clr(err_clr),
    .ch0_sop(ch0_sop), .ch0_eop(ch0_eop), .ch0_valid(ch0_valid),
    .ch1_sop(ch1_sop), .ch1_eop(ch1_eop), .ch1_valid(ch1_valid),
    .adc_mux_s(adc_mux_s), .mux_busy(mux_busy), .switch_done(switch_done), .frame_cnt(frame_cnt),
    .sop_drop_err(sop_drop_err), .frame_timeout(frame_timeout)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-12s got %0d expected %0d @edge %0d", tag, obs, exp, edge_n);
    end else begin
      $display("FAIL %-12s got %0d expected %0d @edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  typedef struct {
    int unsigned sel_edge;
    int unsigned done_edge;
    logic        new_sel;
  } sw_exp_t;

  sw_exp_t sb_q[$];
  logic    mon_en   = 1'b0;
  logic    prev_sel = 1'b0;

  task automatic push_switch(input int unsigned t, input int unsigned g, input logic sel);
    sw_exp_t e;
    e.sel_edge  = t + g + 1;
    e.done_edge = t + g + 1 + SETTLE;
    e.new_sel   = sel;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (adc_mux_s !== prev_sel) begin
        if (sb_q.size() == 0) begin
          check_eq("sel_unexp", 32'(adc_mux_s), 32'(prev_sel));
        end else begin
          check_eq("sel_edge", edge_n, sb_q[0].sel_edge);
          check_eq("sel_val", 32'(adc_mux_s), 32'(sb_q[0].new_sel));
        end
      end
      if (switch_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("done_unexp", 32'(switch_done), 32'd0);
        end else begin
          sw_exp_t e;
          e = sb_q.pop_front();
          check_eq("done_edge", edge_n, e.done_edge);
          check_eq("done_fcnt", 32'(frame_cnt), 32'd0);
          check_eq("done_busy", 32'(mux_busy), 32'd0);
        end
      end
    end
    prev_sel = adc_mux_s;
  end

  // Inputs are applied just after a negedge; each call then advances to the next negedge.
  task automatic drive(input bit src, input bit v, input bit s, input bit e, input bit rq, input bit rs);
    ch0_sop = !src && s;  ch0_eop = !src && e;  ch0_valid = !src && v;
    ch1_sop = src && s;   ch1_eop = src && e;   ch1_valid = src && v;
    sw_req  = rq;
    sw_sel  = rs;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_until(input int unsigned target);
    while (edge_n < target) drive_idle();
  endtask

  task automatic send_frame(input bit src, input int len, input int rq_at, input bit rq_sel,
                            input int rq2_at, input bit rq2_sel, output int unsigned t_eop);
    t_eop = 0;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) t_eop = edge_n + 1;
      drive(src, 1'b1, i == 0, i == len - 1, (i == rq_at) || (i == rq2_at),
            (i == rq2_at) ? rq2_sel : rq_sel);
    end
    drive_idle();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    drive_idle();
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t2;
    rst = 1'b1; cfg_mode = 2'b00; cfg_frames = 8'd2; cfg_guard = 8'd4;
    sw_req = 1'b0; sw_sel = 1'b0; err_clr = 1'b0;
    ch0_sop = 1'b0; ch0_eop = 1'b0; ch0_valid = 1'b0;
    ch1_sop = 1'b0; ch1_eop = 1'b0; ch1_valid = 1'b0;
    repeat (3) drive_idle();
    check_eq("rst_sel", 32'(adc_mux_s), 32'd0);
    check_eq("rst_busy", 32'(mux_busy), 32'd0);
    check_eq("rst_done", 32'(switch_done), 32'd0);
    check_eq("rst_fcnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_drop", 32'(sop_drop_err), 32'd0);
    check_eq("rst_tmo", 32'(frame_timeout), 32'd0);
    rst = 1'b0;
    drive_idle();
    mon_en = 1'b1;

    // Fixed src0: normal, one-beat and short frames count; unqualified and src1 strobes do not
    send_frame(1'b0, 4, -1, 1'b0, -1, 1'b0, t);
    send_frame(1'b0, 1, -1, 1'b0, -1, 1'b0, t);
    send_frame(1'b0, 3, -1, 1'b0, -1, 1'b0, t);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 3, -1, 1'b0, -1, 1'b0, t);
    repeat (4) drive_idle();
    check_eq("m00_fcnt", 32'(frame_cnt), 32'd3);
    check_eq("m00_sel", 32'(adc_mux_s), 32'd0);

    // Alternate every 2 frames, guard 4
    rst = 1'b1; drive_idle(); rst = 1'b0;
    cfg_mode = 2'b10; cfg_frames = 8'd2; cfg_guard = 8'd4;
    drive_idle();
    send_frame(1'b0, 4, -1, 1'b0, -1, 1'b0, t);
    check_eq("alt_fcnt1", 32'(frame_cnt), 32'd1);
    send_frame(1'b0, 4, -1, 1'b0, -1, 1'b0, t);
    push_switch(t, 4, 1'b1);
    check_eq("alt_busy", 32'(mux_busy), 32'd1);
    wait_until(t + 4 + 1 + SETTLE + 2);
    check_eq("alt_sel1", 32'(adc_mux_s), 32'd1);
    check_eq("alt_fcnt0", 32'(frame_cnt), 32'd0);

    // cfg_frames = 0 behaves as 1
    cfg_frames = 8'd0;
    send_frame(1'b1, 3, -1, 1'b0, -1, 1'b0, t);
    push_switch(t, 4, 1'b0);
    wait_until(t + 4 + 1 + SETTLE + 2);

    // Zero guard
    cfg_guard = 8'd0;
    send_frame(1'b0, 3, -1, 1'b0, -1, 1'b0, t);
    push_switch(t, 0, 1'b1);
    wait_until(t + 1 + SETTLE + 2);
    check_eq("g0_sel", 32'(adc_mux_s), 32'd1);

    // Software select: request mid-frame takes effect at eop
    cfg_mode = 2'b11; cfg_guard = 8'd4;
    drive_idle();
    send_frame(1'b1, 6, 2, 1'b0, -1, 1'b0, t);
    push_switch(t, 4, 1'b0);
    wait_until(t + 4 + 1 + SETTLE + 2);
    // Second request cancels the first: no switch
    send_frame(1'b0, 6, 1, 1'b1, 3, 1'b0, t);
    repeat (10) drive_idle();
    check_eq("sw_cancel", 32'(adc_mux_s), 32'd0);
    check_eq("sw_fcnt", 32'(frame_cnt), 32'd1);

    // Guard abort by sop 3 cycles after eop, then switch at that frame's eop
    cfg_mode = 2'b10; cfg_frames = 8'd2; cfg_guard = 8'd10;
    drive_idle();
    send_frame(1'b0, 4, -1, 1'b0, -1, 1'b0, t);
    check_eq("ab_busy1", 32'(mux_busy), 32'd1);
    drive_idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ab_busy0", 32'(mux_busy), 32'd0);
    check_eq("ab_sel", 32'(adc_mux_s), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    t2 = edge_n + 1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push_switch(t2, 10, 1'b1);
    drive_idle();
    check_eq("ab_fcnt", 32'(frame_cnt), 32'd3);

    // src1 sop the cycle after select rises: sticky drop error
    wait_until(t2 + 11);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("drop_set", 32'(sop_drop_err), 32'd1);
    wait_until(t2 + 11 + SETTLE + 3);
    check_eq("drop_hold", 32'(sop_drop_err), 32'd1);
    pulse_err_clr();
    check_eq("drop_clr", 32'(sop_drop_err), 32'd0);

    // Drop coinciding with err_clr: set wins
    cfg_frames = 8'd1; cfg_guard = 8'd2;
    drive_idle();
    send_frame(1'b1, 3, -1, 1'b0, -1, 1'b0, t);
    push_switch(t, 2, 1'b0);
    wait_until(t + 3);
    err_clr = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check_eq("drop_win", 32'(sop_drop_err), 32'd1);
    wait_until(t + 3 + SETTLE + 2);
    pulse_err_clr();
    check_eq("drop_clr2", 32'(sop_drop_err), 32'd0);

    // Reset during SETTLE: select drops back at once
    send_frame(1'b0, 2, -1, 1'b0, -1, 1'b0, t);
    push_switch(t, 2, 1'b1);
    wait_until(t + 4);
    check_eq("mid_sel1", 32'(adc_mux_s), 32'd1);
    mon_en = 1'b0;
    rst = 1'b1; cfg_mode = 2'b00;
    drive_idle();
    check_eq("mid_sel0", 32'(adc_mux_s), 32'd0);
    check_eq("mid_busy", 32'(mux_busy), 32'd0);
    rst = 1'b0;
    drive_idle();
    sb_q.delete();
    mon_en = 1'b1;

    // Frame without eop: watchdog fires only when built in
    send_frame(1'b0, 2, -1, 1'b0, -1, 1'b0, t);
    t = edge_n + 1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_until(t + 15);
    check_eq("tmo_early", 32'(frame_timeout), 32'd0);
    drive_idle();
`ifdef ADC_MUX_CTRL_TIMEOUT_EN
    check_eq("tmo_set", 32'(frame_timeout), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle();
    check_eq("tmo_fcnt", 32'(frame_cnt), 32'd1);
`else
    check_eq("tmo_off", 32'(frame_timeout), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_idle();
    check_eq("tmo_fcnt", 32'(frame_cnt), 32'd2);
`endif
    pulse_err_clr();
    check_eq("tmo_clr", 32'(frame_timeout), 32'd0);

    repeat (4) drive_idle();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
